// File: rtl/apb_sram_wsp_if.sv
// APB3/APB4 bus bundle for the wait-state SRAM slave.
// master drives request fields; slave returns PRDATA/PREADY/PSLVERR.
interface apb_sram_wsp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic [2:0]                PPROT;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_sram_wsp.sv
// Parametrised APB SRAM slave with run-time wait states, byte strobes,
// PPROT/write-protect/range/alignment errors and a saturating error count.
// Ports: PCLK, PRESET (async, active-high), bus (APB slave modport),
//        wait_cfg (wait states per transfer), wr_protect (reject writes),
//        err_count (saturating count of errored completions).
module apb_sram_wsp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 1024,
    parameter int WAIT_W     = 4,
    parameter int PROT_CHECK = 1,
    parameter int ERRCNT_W   = 8
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_sram_wsp_if.slave       bus,
    input  logic [WAIT_W-1:0]   wait_cfg,
    input  logic                wr_protect,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int NB     = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NB);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [IDX_W:0]        DEPTH_L = (IDX_W + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WAIT_W-1:0]     r_cnt;
    logic                  r_err;
    logic [ERRCNT_W-1:0]   r_err_cnt;
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic [IDX_W-1:0]      w_idx;
    logic [MEM_AW-1:0]     w_mem_idx;
    logic                  w_in_range;
    logic                  w_misalign;
    logic                  w_prot_err;
    logic                  w_wp_err;
    logic                  w_err_now;
    logic                  w_setup;
    logic                  w_ready;
    logic                  w_wr_en;
    logic                  w_slverr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_ok;

    assign w_idx      = bus.PADDR[ADDR_WIDTH-1:LSB];
    assign w_mem_idx  = w_idx[MEM_AW-1:0];
    assign w_in_range = ({1'b0, w_idx} < DEPTH_L);
    assign w_misalign = |(bus.PADDR & AMASK);
    assign w_prot_err = (PROT_CHECK != 0) && bus.PPROT[1];
    assign w_wp_err   = bus.PWRITE && wr_protect;
    assign w_err_now  = !w_in_range || w_misalign || w_wp_err || w_prot_err;
    assign w_setup    = bus.PSEL && !bus.PENABLE;

    // Only PPROT[1] (non-secure) matters to this slave.
    assign w_unused_ok = ^{bus.PPROT[2], bus.PPROT[0]};

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!bus.PSEL || r_cnt == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_ready  = (r_state == S_ACCESS) && bus.PSEL && bus.PENABLE &&
                   (r_cnt == '0);
        w_slverr = w_ready && r_err;
        w_rdata  = '0;
        // Range re-check guards the array even if PADDR moved mid-access.
        if (w_ready && !bus.PWRITE && !r_err && w_in_range) begin
            w_rdata = r_mem[w_mem_idx];
        end
    end

    assign bus.PREADY  = w_ready;
    assign bus.PSLVERR = w_slverr;
    assign bus.PRDATA  = w_rdata;

    // Wait counter and error flag are captured at setup only, so later
    // wait_cfg/wr_protect changes do not affect a transfer in flight.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && w_setup) begin
            r_cnt <= wait_cfg;
            r_err <= w_err_now;
        end else if (r_state == S_ACCESS && bus.PSEL && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_err_cnt <= '0;
        end else if (w_slverr && r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_count = r_err_cnt;

    assign w_wr_en = w_ready && bus.PWRITE && !r_err && w_in_range &&
                     !PRESET;

    // Storage is deliberately not reset.
    always_ff @(posedge PCLK) begin
        if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.PSTRB[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= bus.PWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_sram_wsp.sv
// Directed self-checking bench for apb_sram_wsp.
// Covers reset, wait states, strobes, errors, saturation, mid-reset.
module tb_apb_sram_wsp;

    logic       clk;
    logic       rst;
    logic [3:0] wait_cfg;
    logic       wr_protect;
    logic [7:0] err_count;

    int pass_cnt;
    int total_cnt;

    apb_sram_wsp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) bus ();

    apb_sram_wsp #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(13),
        .DEPTH(1024),
        .WAIT_W(4),
        .PROT_CHECK(1),
        .ERRCNT_W(8)
    ) u_dut (
        .PCLK      (clk),
        .PRESET    (rst),
        .bus       (bus),
        .wait_cfg  (wait_cfg),
        .wr_protect(wr_protect),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dirty: PSLVERR or nonzero PRDATA seen before PREADY
    task automatic xfer(
        input  logic        wr,
        input  logic [12:0] addr,
        input  logic [31:0] data,
        input  logic [3:0]  strb,
        input  logic [2:0]  prot,
        output logic [31:0] rdata,
        output logic        slverr,
        output int          cycles,
        output logic        dirty
    );
        dirty = 1'b0;
        @(negedge clk);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = data;
        bus.PSTRB   = strb;
        bus.PPROT   = prot;
        #1;
        if (bus.PREADY || bus.PSLVERR || bus.PRDATA != 0) dirty = 1'b1;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        #1;
        cycles = 1;
        while (!bus.PREADY && cycles < 64) begin
            if (bus.PSLVERR || bus.PRDATA != 0) dirty = 1'b1;
            @(negedge clk);
            #1;
            cycles++;
        end
        rdata  = bus.PRDATA;
        slverr = bus.PSLVERR;
        @(posedge clk);
        #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        bus.PSTRB   = '0;
        bus.PPROT   = '0;
        wait_cfg    = 4'd0;
        wr_protect  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.PREADY !== 1'b0)
            $display("FAIL reset_pready got=%b exp=0", bus.PREADY);
        else pass_cnt++;
        total_cnt++;
        if (bus.PSLVERR !== 1'b0)
            $display("FAIL reset_pslverr got=%b exp=0", bus.PSLVERR);
        else pass_cnt++;
        total_cnt++;
        if (bus.PRDATA !== 32'h0)
            $display("FAIL reset_prdata got=%h exp=0", bus.PRDATA);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 8'd0)
            $display("FAIL reset_errcnt got=%0d exp=0", err_count);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic        se;
        logic        dt;
        int          cy;
        wait_cfg = 4'd0;
        xfer(1'b1, 13'h010, 32'hDEADBEEF, 4'hF, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (cy !== 1 || se !== 1'b0)
            $display("FAIL basic_wr got cyc=%0d err=%b exp cyc=1 err=0",
                     cy, se);
        else pass_cnt++;
        xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (rd !== 32'hDEADBEEF || se !== 1'b0 || cy !== 1)
            $display("FAIL basic_rd got=%h err=%b cyc=%0d exp=deadbeef 0 1",
                     rd, se, cy);
        else pass_cnt++;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        se;
        logic        dt;
        int          cy;
        wait_cfg = 4'd3;
        xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (cy !== 4)
            $display("FAIL wait3_cycles got=%0d exp=4", cy);
        else pass_cnt++;
        total_cnt++;
        if (rd !== 32'hDEADBEEF || dt !== 1'b0)
            $display("FAIL wait3_data got=%h early=%b exp=deadbeef 0",
                     rd, dt);
        else pass_cnt++;
        wait_cfg = 4'd0;
    endtask

    task automatic test_strobes();
        logic [31:0] rd;
        logic        se;
        logic        dt;
        int          cy;
        xfer(1'b1, 13'h010, 32'h11223344, 4'b0101, 3'b000, rd, se, cy, dt);
        xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (rd !== 32'hDE22BE44)
            $display("FAIL strobe_0101 got=%h exp=de22be44", rd);
        else pass_cnt++;
        xfer(1'b1, 13'h010, 32'h55667788, 4'b0000, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (se !== 1'b0)
            $display("FAIL strobe_zero_err got=%b exp=0", se);
        else pass_cnt++;
        xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (rd !== 32'hDE22BE44)
            $display("FAIL strobe_zero_data got=%h exp=de22be44", rd);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        se;
        logic        dt;
        int          cy;
        wait_cfg = 4'd2;
        xfer(1'b0, 13'h1000, 32'h0, 4'h0, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (se !== 1'b1 || rd !== 32'h0 || dt !== 1'b0 || cy !== 3)
            $display("FAIL err_range got err=%b rd=%h early=%b cyc=%0d exp 1 0 0 3",
                     se, rd, dt, cy);
        else pass_cnt++;
        wait_cfg = 4'd0;
        xfer(1'b1, 13'h012, 32'hFFFFFFFF, 4'hF, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (se !== 1'b1)
            $display("FAIL err_misalign got=%b exp=1", se);
        else pass_cnt++;
        wr_protect = 1'b1;
        xfer(1'b1, 13'h010, 32'h00000000, 4'hF, 3'b000, rd, se, cy, dt);
        wr_protect = 1'b0;
        total_cnt++;
        if (se !== 1'b1)
            $display("FAIL err_wrprot got=%b exp=1", se);
        else pass_cnt++;
        xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b010, rd, se, cy, dt);
        total_cnt++;
        if (se !== 1'b1 || rd !== 32'h0)
            $display("FAIL err_pprot got err=%b rd=%h exp 1 0", se, rd);
        else pass_cnt++;
        xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (rd !== 32'hDE22BE44 || se !== 1'b0)
            $display("FAIL err_mem_kept got=%h err=%b exp=de22be44 0", rd, se);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 8'd4)
            $display("FAIL err_count4 got=%0d exp=4", err_count);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [31:0] rd;
        logic        se;
        logic        dt;
        int          cy;
        for (int i = 0; i < 250; i++)
            xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b010, rd, se, cy, dt);
        total_cnt++;
        if (err_count !== 8'd254)
            $display("FAIL sat_254 got=%0d exp=254", err_count);
        else pass_cnt++;
        xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b010, rd, se, cy, dt);
        total_cnt++;
        if (err_count !== 8'd255)
            $display("FAIL sat_255 got=%0d exp=255", err_count);
        else pass_cnt++;
        for (int i = 0; i < 49; i++)
            xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b010, rd, se, cy, dt);
        total_cnt++;
        if (err_count !== 8'd255)
            $display("FAIL sat_hold got=%0d exp=255", err_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        se;
        logic        dt;
        int          cy;
        wait_cfg = 4'd5;
        @(negedge clk);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 13'h010;
        bus.PWDATA  = 32'hCAFEF00D;
        bus.PSTRB   = 4'hF;
        bus.PPROT   = 3'b000;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.PREADY !== 1'b0)
            $display("FAIL midrst_pready got=%b exp=0", bus.PREADY);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        // Still selected and enabled, but an IDLE slave must not complete.
        #1;
        total_cnt++;
        if (bus.PREADY !== 1'b0)
            $display("FAIL midrst_idle got=%b exp=0", bus.PREADY);
        else pass_cnt++;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        total_cnt++;
        if (err_count !== 8'd0)
            $display("FAIL midrst_errcnt got=%0d exp=0", err_count);
        else pass_cnt++;
        wait_cfg = 4'd0;
        xfer(1'b0, 13'h010, 32'h0, 4'h0, 3'b000, rd, se, cy, dt);
        total_cnt++;
        if (rd !== 32'hDE22BE44)
            $display("FAIL midrst_mem got=%h exp=de22be44", rd);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_wait_states();
        test_strobes();
        test_errors();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
